// File: rtl/lsu_clkgen_pkg.sv
// Shared defaults and counter sizing helper for the LSU pipe clock generator.
package lsu_clkgen_pkg;

  localparam int DEF_NUM_STAGES    = 5;
  localparam int DEF_FREEZE_STAGES = 3;
  localparam int DEF_HOLD_CYCLES   = 1;
  localparam int DEF_IDLE_TIMEOUT  = 8;
  localparam int DEF_NUM_BUFS      = 4;

  // Bits needed for a down-counter that must hold the value itself.
  function automatic int cnt_width(input int value);
    return (value < 1) ? 1 : $clog2(value + 1);
  endfunction

endpackage

// File: rtl/lsu_clken_stage.sv
// One pipe stage: c1 history flop, c2 hold-over counter and freeze masking.
module lsu_clken_stage
  import lsu_clkgen_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter bit FROZEN      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic c1_req,
  input  logic store_req,
  input  logic clk_override,
  input  logic freeze,
  output logic c1_clken,
  output logic c2_clken,
  output logic store_clken,
  output logic c1q
);

  localparam int HOLD_W = cnt_width(HOLD_CYCLES);

  logic [HOLD_W-1:0] hold_cnt;
  logic              frz;
  logic              c1_raw;

  // Freeze only applies to the early stages and beats override and new valids.
  assign frz         = FROZEN & freeze;
  assign c1_raw      = c1_req | clk_override;
  assign c1_clken    = c1_raw & ~frz;
  assign c2_clken    = (c1_raw | (hold_cnt != '0)) & ~frz;
  assign store_clken = ((c1_clken & store_req) | clk_override) & ~frz;

  always_ff @(posedge clk) begin
    if (rst) begin
      c1q      <= 1'b0;
      hold_cnt <= '0;
    end else begin
      c1q <= c1_clken;
      if (frz) begin
        hold_cnt <= hold_cnt;
      end else if (c1_clken) begin
        hold_cnt <= HOLD_W'(HOLD_CYCLES);
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end
    end
  end

endmodule

// File: rtl/rvoclkhdr.sv
// Latch-based clock header: enable is captured while clk is low, scan_mode forces it on.
module rvoclkhdr (
  input  logic clk,
  input  logic en,
  input  logic scan_mode,
  output logic l1clk
);

  logic en_lat;

  always_latch begin
    if (!clk) en_lat = en | scan_mode;
  end

  assign l1clk = clk & en_lat;

endmodule

// File: rtl/lsu_pipe_clkgen.sv
// LSU pipeline clock-enable generator with free-running domain hysteresis and bus buffer clocks.
module lsu_pipe_clkgen
  import lsu_clkgen_pkg::*;
#(
  parameter int NUM_STAGES    = DEF_NUM_STAGES,
  parameter int FREEZE_STAGES = DEF_FREEZE_STAGES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int IDLE_TIMEOUT  = DEF_IDLE_TIMEOUT,
  parameter int NUM_BUFS      = DEF_NUM_BUFS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_mode,
  input  logic                  clk_override,
  input  logic                  freeze,
  input  logic [NUM_STAGES:0]   stage_valid,
  input  logic [NUM_STAGES:0]   stage_store,
  input  logic                  dma_req,
  input  logic                  dma_write,
  input  logic [NUM_BUFS-1:0]   buf_active,
  input  logic                  bus_clk_en,
  output logic [NUM_STAGES-1:0] c1_clken,
  output logic [NUM_STAGES-1:0] c2_clken,
  output logic [NUM_STAGES-1:0] store_clken,
  output logic [NUM_STAGES-1:0] c1_clk,
  output logic [NUM_STAGES-1:0] c2_clk,
  output logic [NUM_STAGES-1:0] store_clk,
  output logic [NUM_BUFS-1:0]   buf_clk,
  output logic                  free_clken,
  output logic                  free_clk,
  output logic                  idle
);

  localparam int IDLE_W = cnt_width(IDLE_TIMEOUT);

  logic [NUM_STAGES-1:0] c1q;
  logic [IDLE_W-1:0]     idle_cnt;
  logic                  activity;
  logic [1:0]            unused_bits;

  // The free clock must outlive the longest c1q/hold chain, or state could freeze non-zero.
  if (IDLE_TIMEOUT < NUM_STAGES + HOLD_CYCLES) begin : g_bad_timeout
    $error("lsu_pipe_clkgen: IDLE_TIMEOUT must be at least NUM_STAGES+HOLD_CYCLES");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
    $error("lsu_pipe_clkgen: HOLD_CYCLES must be within 1..15");
  end

  assign unused_bits = {c1q[NUM_STAGES-1], stage_store[NUM_STAGES]};

  assign activity = (|stage_valid) | (|buf_active) | dma_req | clk_override;

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (activity) begin
      idle_cnt <= IDLE_W'(IDLE_TIMEOUT);
    end else if (idle_cnt != '0) begin
      idle_cnt <= idle_cnt - IDLE_W'(1);
    end
  end

  // Reset keeps the free domain ticking so the stage flops clear synchronously.
  assign free_clken = activity | (idle_cnt != '0) | rst;
  assign idle       = ~free_clken;

  rvoclkhdr u_free_hdr (
    .clk       (clk),
    .en        (free_clken),
    .scan_mode (scan_mode),
    .l1clk     (free_clk)
  );

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    logic c1_req;
    logic store_req;

    if (g == 0) begin : g_first
      assign c1_req    = stage_valid[0] | dma_req;
      assign store_req = stage_store[0] | dma_write;
    end else begin : g_rest
      assign c1_req    = stage_valid[g] | c1q[g-1];
      assign store_req = stage_store[g];
    end

    lsu_clken_stage #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .FROZEN      (g < FREEZE_STAGES)
    ) u_stage (
      .clk          (free_clk),
      .rst          (rst),
      .c1_req       (c1_req),
      .store_req    (store_req),
      .clk_override (clk_override),
      .freeze       (freeze),
      .c1_clken     (c1_clken[g]),
      .c2_clken     (c2_clken[g]),
      .store_clken  (store_clken[g]),
      .c1q          (c1q[g])
    );

    rvoclkhdr u_c1_hdr (
      .clk       (clk),
      .en        (c1_clken[g]),
      .scan_mode (scan_mode),
      .l1clk     (c1_clk[g])
    );

    rvoclkhdr u_c2_hdr (
      .clk       (clk),
      .en        (c2_clken[g]),
      .scan_mode (scan_mode),
      .l1clk     (c2_clk[g])
    );

    rvoclkhdr u_store_hdr (
      .clk       (clk),
      .en        (store_clken[g]),
      .scan_mode (scan_mode),
      .l1clk     (store_clk[g])
    );
  end

  for (genvar j = 0; j < NUM_BUFS; j++) begin : g_buf
    rvoclkhdr u_buf_hdr (
      .clk       (clk),
      .en        ((buf_active[j] & bus_clk_en) | clk_override),
      .scan_mode (scan_mode),
      .l1clk     (buf_clk[j])
    );
  end

endmodule

// File: tb/tb_lsu_pipe_clkgen.sv
// Randomized and directed bench for lsu_pipe_clkgen against a cycle-level behavioural model.
module tb_lsu_pipe_clkgen;

  localparam logic [4:0] C1_TAB [0:6] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h00, 5'h00};
  localparam logic [4:0] C2_TAB [0:6] = '{5'h01, 5'h03, 5'h06, 5'h0c, 5'h18, 5'h10, 5'h00};

  logic       clk;
  logic       rst, scan_mode, clk_override, freeze, dma_req, dma_write, bus_clk_en;
  logic [5:0] stage_valid, stage_store;
  logic [3:0] buf_active;

  logic [4:0] c1_clken, c2_clken, store_clken, c1_clk, c2_clk, store_clk;
  logic [3:0] buf_clk;
  logic       free_clken, free_clk, idle;

  logic [4:0] c1_clken_b, c2_clken_b, store_clken_b, c1_clk_b, c2_clk_b, store_clk_b;
  logic [3:0] buf_clk_b;
  logic       free_clken_b, free_clk_b, idle_b;

  int compared   = 0;
  int mismatched = 0;
  bit pending    = 1'b0;

  // Model state: stage index 1..5, counters as plain integers.
  int m_c1q    [1:5];
  int m_hold_a [1:5];
  int m_hold_b [1:5];
  int m_idle;

  logic [4:0] exp_c1, exp_c2, exp_c2b, exp_st;
  logic [3:0] exp_buf;
  logic       exp_free, exp_act;

  lsu_pipe_clkgen dut (
    .clk(clk), .rst(rst), .scan_mode(scan_mode), .clk_override(clk_override),
    .freeze(freeze), .stage_valid(stage_valid), .stage_store(stage_store),
    .dma_req(dma_req), .dma_write(dma_write), .buf_active(buf_active),
    .bus_clk_en(bus_clk_en), .c1_clken(c1_clken), .c2_clken(c2_clken),
    .store_clken(store_clken), .c1_clk(c1_clk), .c2_clk(c2_clk),
    .store_clk(store_clk), .buf_clk(buf_clk), .free_clken(free_clken),
    .free_clk(free_clk), .idle(idle)
  );

  lsu_pipe_clkgen #(.HOLD_CYCLES(3)) dut_hold3 (
    .clk(clk), .rst(rst), .scan_mode(scan_mode), .clk_override(clk_override),
    .freeze(freeze), .stage_valid(stage_valid), .stage_store(stage_store),
    .dma_req(dma_req), .dma_write(dma_write), .buf_active(buf_active),
    .bus_clk_en(bus_clk_en), .c1_clken(c1_clken_b), .c2_clken(c2_clken_b),
    .store_clken(store_clken_b), .c1_clk(c1_clk_b), .c2_clk(c2_clk_b),
    .store_clk(store_clk_b), .buf_clk(buf_clk_b), .free_clken(free_clken_b),
    .free_clk(free_clk_b), .idle(idle_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic computeExpected();
    exp_act = (|stage_valid) || (|buf_active) || dma_req || clk_override;
    for (int i = 1; i <= 5; i++) begin
      bit frz, raw, c1, st_req;
      frz = (i <= 3) && freeze;
      if (i == 1) begin
        raw    = stage_valid[0] || dma_req || clk_override;
        st_req = stage_store[0] || dma_write;
      end else begin
        raw    = stage_valid[i-1] || (m_c1q[i-1] != 0) || clk_override;
        st_req = stage_store[i-1];
      end
      c1 = raw && !frz;
      exp_c1[i-1]  = c1;
      exp_c2[i-1]  = !frz && (raw || m_hold_a[i] > 0);
      exp_c2b[i-1] = !frz && (raw || m_hold_b[i] > 0);
      exp_st[i-1]  = !frz && ((c1 && st_req) || clk_override);
    end
    for (int j = 0; j < 4; j++) exp_buf[j] = (buf_active[j] && bus_clk_en) || clk_override;
    exp_free = exp_act || (m_idle > 0) || rst;
  endtask

  always @(posedge clk) begin
    computeExpected();
    if (rst) begin
      for (int i = 1; i <= 5; i++) begin
        m_c1q[i] = 0; m_hold_a[i] = 0; m_hold_b[i] = 0;
      end
      m_idle = 0;
    end else begin
      for (int i = 1; i <= 5; i++) begin
        m_c1q[i] = exp_c1[i-1];
        if (!((i <= 3) && freeze)) begin
          m_hold_a[i] = exp_c1[i-1] ? 1 : ((m_hold_a[i] > 0) ? m_hold_a[i] - 1 : 0);
          m_hold_b[i] = exp_c1[i-1] ? 3 : ((m_hold_b[i] > 0) ? m_hold_b[i] - 1 : 0);
        end
      end
      m_idle = exp_act ? 8 : ((m_idle > 0) ? m_idle - 1 : 0);
    end
  end

  // Gated clocks are sampled while clk is high, after the header has latched its enable.
  task automatic checkClocks();
    @(posedge clk);
    #1;
    checkOutput("buf_clk", buf_clk, exp_buf | {4{scan_mode}});
    checkOutput("free_clk", free_clk, exp_free | scan_mode);
    pending = 1'b0;
  endtask

  task automatic applyStimulus(input logic r, input logic sm, input logic ov, input logic fz,
                               input logic [5:0] sv, input logic [5:0] ss, input logic dma,
                               input logic dw, input logic [3:0] ba, input logic be);
    if (pending) checkClocks();
    @(negedge clk);
    rst = r; scan_mode = sm; clk_override = ov; freeze = fz;
    stage_valid = sv; stage_store = ss; dma_req = dma; dma_write = dw;
    buf_active = ba; bus_clk_en = be;
    #1;
    computeExpected();
    checkOutput("c1_clken", c1_clken, exp_c1);
    checkOutput("c2_clken", c2_clken, exp_c2);
    checkOutput("store_clken", store_clken, exp_st);
    checkOutput("c2_clken_hold3", c2_clken_b, exp_c2b);
    checkOutput("free_clken", free_clken, exp_free);
    checkOutput("idle", idle, !exp_free);
    pending = 1'b1;
  endtask

  task automatic quietCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 6'h00, 6'h00, 0, 0, 4'h0, 0);
  endtask

  task automatic runRandom(input int segments);
    int mode, len;
    logic r, sm, ov, fz, dma, dw, be;
    logic [5:0] sv, ss;
    logic [3:0] ba;
    for (int seg = 0; seg < segments; seg++) begin
      mode = $urandom_range(0, 2);
      len  = $urandom_range(4, 20);
      for (int k = 0; k < len; k++) begin
        r  = ($urandom_range(0, 47) == 0);
        sm = ($urandom_range(0, 15) == 0);
        fz = ($urandom_range(0, 3) == 0);
        be = 1'($urandom);
        ov = (mode == 2) && ($urandom_range(0, 7) == 0);
        if (mode == 0) begin
          {sv, ss, dma, dw, ba} = '0;
        end else begin
          sv  = 6'($urandom) & 6'($urandom) & ((mode == 1) ? 6'($urandom) : 6'h3f);
          ss  = 6'($urandom);
          dma = ($urandom_range(0, 5) == 0);
          dw  = 1'($urandom);
          ba  = 4'($urandom) & 4'($urandom);
        end
        applyStimulus(r, sm, ov, fz, sv, ss, dma, dw, ba, be);
      end
    end
  endtask

  initial begin
    rst = 1'b1; scan_mode = 1'b0; clk_override = 1'b0; freeze = 1'b0;
    stage_valid = '0; stage_store = '0; dma_req = 1'b0; dma_write = 1'b0;
    buf_active = '0; bus_clk_en = 1'b0;

    applyStimulus(1, 0, 0, 0, 6'h00, 6'h00, 0, 0, 4'h0, 0);
    applyStimulus(1, 0, 0, 0, 6'h00, 6'h00, 0, 0, 4'h0, 0);
    checkOutput("rst_free_clken", free_clken, 1'b1);
    checkOutput("rst_idle", idle, 1'b0);
    checkOutput("rst_c1", c1_clken, 5'h00);
    checkOutput("rst_c2", c2_clken, 5'h00);
    checkOutput("rst_store", store_clken, 5'h00);

    quietCycles(1);
    checkOutput("post_rst_free_clken", free_clken, 1'b0);
    checkOutput("post_rst_idle", idle, 1'b1);

    // Single decode valid ripples down the pipe with one cycle of c2 hold-over.
    for (int k = 0; k < 7; k++) begin
      if (k == 0) applyStimulus(0, 0, 0, 0, 6'h01, 6'h00, 0, 0, 4'h0, 0);
      else        quietCycles(1);
      checkOutput("pulse_c1", c1_clken, C1_TAB[k]);
      checkOutput("pulse_c2", c2_clken, C2_TAB[k]);
      checkOutput("pulse_store", store_clken, 5'h00);
    end

    applyStimulus(0, 0, 0, 1, 6'h02, 6'h02, 0, 0, 4'h0, 0);
    checkOutput("freeze_c1_s2", c1_clken[1], 1'b0);
    checkOutput("freeze_store_s2", store_clken[1], 1'b0);
    applyStimulus(0, 0, 0, 0, 6'h02, 6'h02, 0, 0, 4'h0, 0);
    checkOutput("nofreeze_c1_s2", c1_clken[1], 1'b1);
    checkOutput("nofreeze_store_s2", store_clken[1], 1'b1);
    quietCycles(8);

    applyStimulus(0, 0, 0, 1, 6'h08, 6'h00, 0, 0, 4'h0, 0);
    checkOutput("hold3_c2_s4_t0", c2_clken_b[3], 1'b1);
    for (int k = 1; k <= 4; k++) begin
      quietCycles(1);
      checkOutput("hold3_c2_s4", c2_clken_b[3], (k <= 3) ? 1'b1 : 1'b0);
    end

    applyStimulus(0, 0, 0, 0, 6'h00, 6'h00, 0, 0, 4'h1, 0);
    for (int k = 1; k <= 9; k++) begin
      quietCycles(1);
      if (k == 8) checkOutput("idle_t8_free_clken", free_clken, 1'b1);
      if (k == 9) begin
        checkOutput("idle_t9_free_clken", free_clken, 1'b0);
        checkOutput("idle_t9_idle", idle, 1'b1);
      end
    end
    applyStimulus(0, 0, 0, 0, 6'h00, 6'h00, 0, 0, 4'h1, 0);
    checkOutput("wake_free_clken", free_clken, 1'b1);

    applyStimulus(0, 0, 1, 1, 6'h00, 6'h00, 0, 0, 4'h0, 0);
    checkOutput("ovr_freeze_c1", c1_clken, 5'h18);
    checkOutput("ovr_freeze_c2", c2_clken, 5'h18);
    checkOutput("ovr_freeze_store", store_clken, 5'h18);
    checkClocks();
    checkOutput("ovr_buf_clk", buf_clk, 4'hf);
    quietCycles(6);

    applyStimulus(0, 0, 0, 0, 6'h01, 6'h00, 0, 0, 4'h0, 0);
    quietCycles(1);
    applyStimulus(1, 0, 0, 1, 6'h00, 6'h00, 0, 0, 4'h0, 0);
    checkOutput("rst_freeze_c2_s1", c2_clken_b[0], 1'b0);
    checkOutput("rst_freeze_free_clken", free_clken, 1'b1);
    quietCycles(1);
    checkOutput("after_rst_c2_hold3", c2_clken_b, 5'h00);
    checkOutput("after_rst_c1", c1_clken, 5'h00);
    checkOutput("after_rst_idle", idle, 1'b1);

    runRandom(40);
    if (pending) checkClocks();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lsu_pipe_clkgen.md
LSU_PIPE_CLKGEN -- requirements
Module: lsu_pipe_clkgen

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, meaning the number of pipe stages clocked (dc1..dcN).
REQ-002 SHALL have parameter FREEZE_STAGES, default 3, meaning stages 1..FREEZE_STAGES are gated by freeze.
REQ-003 SHALL have parameter HOLD_CYCLES, default 1, range 1..15, meaning the c2 enable hold-over after the last c1 enable.
REQ-004 SHALL have parameter IDLE_TIMEOUT, default 8, meaning free-clock hysteresis in cycles.
REQ-005 SHALL have parameter NUM_BUFS, default 4, meaning the number of bus-buffer clock domains.
REQ-006 Ports (name  direction  width  meaning), clock and reset first:
- clk  in  1  core clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- scan_mode  in  1  forces all gated clocks on.
- clk_override  in  1  chicken bit that forces enables on.
- freeze  in  1  pipe freeze.
- stage_valid  in  NUM_STAGES+1  valid per stage; index 0 = decode.
- stage_store  in  NUM_STAGES+1  store qualifier per stage.
- dma_req  in  1  DMA DCCM request.
- dma_write  in  1  DMA write.
- buf_active  in  NUM_BUFS  per-buffer activity.
- bus_clk_en  in  1  bus clock ratio enable.
- c1_clken, c2_clken, store_clken  out  NUM_STAGES  per-stage enables; bit i-1 = stage i.
- c1_clk, c2_clk, store_clk  out  NUM_STAGES  gated clocks.
- buf_clk  out  NUM_BUFS  gated buffer clocks.
- free_clken, free_clk  out  1  free-domain enable and clock.
- idle  out  1  block idle.
REQ-007 Reset is synchronous and active-high on rst; one clock, clk.

Function
REQ-010 c1_clken[1] SHALL equal stage_valid[0] | dma_req | clk_override.
REQ-011 For i>1, c1_clken[i] SHALL equal stage_valid[i-1] | c1q[i-1] | clk_override, where c1q[k] is c1_clken[k] registered on free_clk.
REQ-012 Each stage SHALL own a hold counter:
- loads HOLD_CYCLES when c1_clken[i]=1;
- otherwise decrements, saturating at 0.
REQ-013 c2_clken[i] SHALL equal c1_clken[i] | (hold_cnt[i]!=0) | clk_override. With HOLD_CYCLES=1, c2 SHALL be asserted for exactly one cycle past c1.
REQ-014 store_clken[1] SHALL equal (c1_clken[1] & (stage_store[0] | dma_write)) | clk_override. For i>1, store_clken[i] SHALL equal (c1_clken[i] & stage_store[i-1]) | clk_override.
REQ-015 For i<=FREEZE_STAGES, c1, c2 and store enables SHALL be ANDed with ~freeze. Freeze SHALL win over both clk_override and a new valid.
REQ-016 While freeze=1, hold counters of frozen stages SHALL hold their value (no decrement). Counting SHALL resume on the cycle after freeze drops.
REQ-017 buf clock j SHALL be enabled by (buf_active[j] & bus_clk_en) | clk_override.
REQ-018 activity SHALL be defined as: any stage_valid | any buf_active | dma_req | clk_override.
REQ-019 An idle counter on clk SHALL:
- load IDLE_TIMEOUT on activity;
- otherwise decrement, saturating at 0.
REQ-020 free_clken SHALL equal activity | (idle_cnt!=0) | rst.
REQ-021 idle SHALL equal ~free_clken.
REQ-022 IDLE_TIMEOUT < NUM_STAGES+HOLD_CYCLES SHALL be an elaboration error; this guarantees every c1q and hold counter is 0 before free_clk stops.
REQ-023 All enable outputs SHALL be combinational, with zero latency from inputs.
REQ-024 All gated clocks SHALL be produced through clock headers that honour scan_mode.

Reset
REQ-030 On rst, all c1q, hold counters and idle_cnt SHALL be 0 by the next clk edge.
REQ-031 With rst=1 and all inputs 0: free_clken=1, idle=0, and all other enables 0.
REQ-032 On the cycle after rst deasserts with no activity: free_clken=0 and idle=1.
REQ-033 rst asserted mid-operation SHALL clear all hold state in one cycle, regardless of freeze.

Structure
REQ-040 The package lsu_clkgen_pkg SHALL hold:
- parameter defaults;
- a function returning the hold/idle counter width (clog2 of value+1).
REQ-041 Sub-module lsu_clken_stage SHALL implement one stage (c1q flop, hold counter, freeze masking) and be instantiated NUM_STAGES times in a generate loop.
REQ-042 Clock gating SHALL use the existing rvoclkhdr cell. No other clock SHALL be derived.

Verification (default parameters)
REQ-050 Single stage_valid[0] pulse at cycle T → c1_clken[i] at T+i-1 for i=1..5, each for one cycle; c2_clken[i] asserted at T+i-1 and T+i; store_clken stays 0.
REQ-051 stage_valid[1]=1 with stage_store[1]=1 at T, freeze=1 at T → c1_clken[2]=0 and store_clken[2]=0 at T; with freeze=0, store_clken[2]=1 at T.
REQ-052 HOLD_CYCLES=3, c1_clken[4] pulse at T, freeze irrelevant for stage 4 → c2_clken[4]=1 for T..T+3, then 0 at T+4.
REQ-053 Last activity at T → free_clken=1 through T+8, 0 at T+9, idle=1 at T+9; new buf_active at T+10 → free_clken=1 in the same cycle.
REQ-054 clk_override=1 with freeze=1 → enables for stages 1..3 are 0; stages 4..5 and all buf clocks are 1.
REQ-055 rst asserted while hold_cnt=2 and freeze=1 → all counters 0 next cycle; after rst release, idle=1 within one cycle.
